// File: rtl/div3_pkg.sv
// Shared constants and flag layout for the divide-by-3 family and its inverse.
package div3_pkg;

  localparam int QW    = 15;
  localparam int XW    = 16;
  localparam int RW    = 2;
  localparam int SPLIT = 8;

  // Largest quotient whose canonical reconstruction still fits in XW bits.
  localparam int MAX_Q = ((1 << XW) - 1) / 3;

  typedef enum int {
    ERR_BAD_R = 0,
    ERR_OVF   = 1
  } err_bit_e;

  localparam int ERR_W = 2;
  typedef logic [ERR_W-1:0] err_flags_t;

endpackage

// File: rtl/mul3_add_16_if.sv
// Input/output stream bundle of the multiply-by-3-and-add pipeline.
interface mul3_add_16_if;
  import div3_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] in_q;
  logic [RW-1:0] in_r;
  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] out_x;
  logic          out_bad_r;
  logic          out_ovf;

  modport slave (
    input  in_valid, in_q, in_r, out_ready,
    output in_ready, out_valid, out_x, out_bad_r, out_ovf
  );

  modport master (
    output in_valid, in_q, in_r, out_ready,
    input  in_ready, out_valid, out_x, out_bad_r, out_ovf
  );

endinterface

// File: rtl/mul3_add_16_split_add3.sv
// Three-operand adder slice: two W-bit operands plus a 0..3 carry-in, 2-bit carry-out.
module split_add3 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   cin,
  output logic [W-1:0] sum,
  output logic [1:0]   cout
);

  logic [W+1:0] total;

  // Two W-bit operands plus at most 3 need W+2 bits, so the carry is 0..2.
  assign total = {2'b00, a} + {2'b00, b} + {{W{1'b0}}, cin};
  assign sum   = total[W-1:0];
  assign cout  = total[W+1:W];

endmodule

// File: rtl/mul3_add_16.sv
// Two-stage elastic pipeline computing X = 3*Q + R with the carry chain split at SPLIT.
module mul3_add_16
  import div3_pkg::*;
(
  input  logic clk,
  input  logic rst,
  mul3_add_16_if.slave bus
);

  localparam int HW = XW - SPLIT;

  logic          v1, v2;
  logic          adv1, adv2;

  logic [XW-1:0] q_ext, q_dbl;
  logic [SPLIT-1:0] lo_d;
  logic [1:0]       cy_d;

  logic [SPLIT-1:0] lo1;
  logic [1:0]       cy1;
  logic [HW-1:0]    up2_1, up1_1;
  logic             bad1;

  logic [HW-1:0]    hi_sum;
  logic [1:0]       hi_cy;
  logic [XW+1:0]    full;

  logic [XW-1:0]    x2;
  err_flags_t       flags2;

  // Only out_ready reaches in_ready combinationally; data paths are all registered.
  assign adv2         = !v2 || bus.out_ready;
  assign adv1         = !v1 || adv2;
  assign bus.in_ready = adv1;

  // 3*q is formed as (q<<1) + q in the full result width.
  assign q_ext = XW'(bus.in_q);
  assign q_dbl = q_ext << 1;

  split_add3 #(.W(SPLIT)) u_lo (
    .a    (q_dbl[SPLIT-1:0]),
    .b    (q_ext[SPLIT-1:0]),
    .cin  (bus.in_r),
    .sum  (lo_d),
    .cout (cy_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: every stage data register is reset, not just the valids, so out_x
  // reads 0 after reset and no stale operand can resurface.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      lo1   <= '0;
      cy1   <= '0;
      up2_1 <= '0;
      up1_1 <= '0;
      bad1  <= 1'b0;
    end else if (adv1) begin
      v1 <= bus.in_valid;
      // A bubble only clears v1; operands hold so stage 2 recomputes the same value.
      if (bus.in_valid) begin
        lo1   <= lo_d;
        cy1   <= cy_d;
        up2_1 <= q_dbl[XW-1:SPLIT];
        up1_1 <= q_ext[XW-1:SPLIT];
        bad1  <= (bus.in_r == 2'd3);
      end
    end
  end

  split_add3 #(.W(HW)) u_hi (
    .a    (up2_1),
    .b    (up1_1),
    .cin  (cy1),
    .sum  (hi_sum),
    .cout (hi_cy)
  );

  assign full = {hi_cy, hi_sum, lo1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2     <= 1'b0;
      x2     <= '0;
      flags2 <= '0;
    end else if (adv2) begin
      v2                <= v1;
      x2                <= full[XW-1:0];
      flags2[ERR_OVF]   <= |full[XW+1:XW];
      flags2[ERR_BAD_R] <= bad1;
    end
  end

  assign bus.out_valid = v2;
  assign bus.out_x     = x2;
  assign bus.out_ovf   = flags2[ERR_OVF];
  assign bus.out_bad_r = flags2[ERR_BAD_R];

endmodule

// File: tb/tb_mul3_add_16.sv
// Directed and round-trip bench for mul3_add_16 with a scoreboard queue.
module tb_mul3_add_16;
  import div3_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul3_add_16_if bus ();

  mul3_add_16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [XW-1:0] x;
    logic          bad;
    logic          ovf;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  bit            rand_ready = 1'b0;
  bit            last_stall = 1'b0;
  logic [XW-1:0] last_x = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int q, input int r);
    exp_t e;
    int   total;
    total = 3 * q + r;
    e.x   = total[XW-1:0];
    e.ovf = (total >= (1 << XW));
    e.bad = (r == 3);
    return e;
  endfunction

  // One clock: sample at negedge, score transfers, then move past the rising edge.
  task automatic tick(output bit acc);
    exp_t e;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    if (last_stall) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_x", bus.out_x, last_x);
    end
    if (bus.out_valid && bus.out_ready) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_x", bus.out_x, e.x);
        chk("out_bad_r", bus.out_bad_r, e.bad);
        chk("out_ovf", bus.out_ovf, e.ovf);
      end
    end
    if (acc) sb.push_back(model(bus.in_q, bus.in_r));
    last_stall = bus.out_valid && !bus.out_ready;
    last_x     = bus.out_x;
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(3) != 0);
  endtask

  task automatic send(input int q, input int r);
    bit acc;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_q     = q[QW-1:0];
    bus.in_r     = r[RW-1:0];
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 1000);
    if (!acc) chk("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      tick(acc);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int idx;
    int accepts;
    int x;

    bus.in_valid  = 1'b0;
    bus.in_q      = '0;
    bus.in_r      = '0;
    bus.out_ready = 1'b0;

    // Reset state, then synchronous release.
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_x", bus.out_x, 0);
    chk("rst_flags", {bus.out_bad_r, bus.out_ovf}, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("empty_in_ready", bus.in_ready, 1);

    // Canonical values with latency check on the first.
    bus.out_ready = 1'b1;
    send(MAX_Q, 0);
    chk("lat_stage1", bus.out_valid, 0);
    tick(acc);
    chk("lat_stage2", bus.out_valid, 1);
    drain();
    send(0, 2);
    send(85, 1);
    drain();

    // Overflow and non-canonical remainder.
    send(MAX_Q, 1);
    send(32767, 3);
    drain();

    // Backpressure: 5 stalled cycles, then release with no bubble.
    bus.out_ready = 1'b0;
    idx     = 0;
    accepts = 0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_q     = QW'(idx + 1);
      bus.in_r     = '0;
      tick(acc);
      if (acc) begin
        idx++;
        accepts++;
      end
      if (bus.out_valid) chk("bp_x", bus.out_x, 3);
    end
    chk("bp_accepts", accepts, 2);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    #1;
    chk("no_bubble_in_ready", bus.in_ready, 1);
    while (idx < 4) begin
      send(idx + 1, 0);
      idx++;
    end
    drain();

    // Asynchronous reset with both stages full.
    bus.out_ready = 1'b0;
    send(100, 0);
    send(200, 0);
    chk("pre_rst_valid", bus.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_x", bus.out_x, 0);
    sb.delete();
    last_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) tick(acc);
    chk("post_rst_valid", bus.out_valid, 0);
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Round trip: X -> (X/3, X%3) -> X, with random downstream stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 600; i++) send(i / 3, i % 3);
    for (int i = 65535; i > 65000; i--) send(i / 3, i % 3);
    for (int i = 0; i < 800; i++) begin
      x = $urandom_range(65535);
      send(x / 3, x % 3);
    end
    drain();
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
